// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse_debouncer / pulse_extender pair.
// State encoding and default widths live here so both blocks agree.
package pulse_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW,
    COUNT_HIGH,
    STABLE_HIGH,
    COUNT_LOW
  } pd_state_e;

  localparam int PD_VALUE_WIDTH       = 8;
  localparam int PD_DEFAULT_THRESHOLD = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous line.
// All stages clear to 0 on synchronous active-low reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= '0;
    end else begin
      r <= {r[STAGES-2:0], d};
    end
  end

  assign q = r[STAGES-1];

endmodule

// File: rtl/pulse_debouncer.sv
// Synchronises and debounces a raw input, emitting one-cycle pulses
// on debounced rising/falling edges; threshold is run-time loadable.
module pulse_debouncer
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int VALUE_WIDTH       = PD_VALUE_WIDTH,
  parameter int DEFAULT_THRESHOLD = PD_DEFAULT_THRESHOLD
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic                   in_set,
  input  logic [VALUE_WIDTH-1:0] in_value,
  output logic                   out_ack,
  input  logic                   in_signal,
  output logic                   out_level,
  output logic                   out_signal,
  output logic                   out_fall
);

  typedef logic [VALUE_WIDTH-1:0] val_t;

  localparam val_t ONE     = val_t'(1);
  localparam val_t THR_RST = val_t'(DEFAULT_THRESHOLD);

  logic s;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (in_clock),
    .rst_n(in_reset),
    .d    (in_signal),
    .q    (s)
  );

  pd_state_e state, state_n;
  val_t      thr, thr_n;
  val_t      cnt, cnt_n;
  val_t      thr_eff;
  logic      set_d;
  logic      load;
  logic      level_n;
  logic      rise_n;
  logic      fall_n;
  logic      done;

  logic [VALUE_WIDTH:0] cnt_inc;

  assign load    = in_set & ~set_d;
  assign thr_eff = (thr == '0) ? ONE : thr;
  assign cnt_inc = {1'b0, cnt} + {{VALUE_WIDTH{1'b0}}, 1'b1};
  // Counter is 0 in both stable states, so done also covers threshold 1
  assign done    = cnt_inc >= {1'b0, thr_eff};

  always_comb begin
    state_n = state;
    thr_n   = thr;
    cnt_n   = cnt;
    level_n = out_level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (load) begin
      thr_n   = in_value;
      cnt_n   = '0;
      state_n = out_level ? STABLE_HIGH : STABLE_LOW;
    end else begin
      unique case (state)
        STABLE_LOW: begin
          if (s) begin
            if (done) begin
              level_n = 1'b1;
              rise_n  = 1'b1;
              state_n = STABLE_HIGH;
            end else begin
              cnt_n   = cnt_inc[VALUE_WIDTH-1:0];
              state_n = COUNT_HIGH;
            end
          end
        end
        COUNT_HIGH: begin
          if (!s) begin
            cnt_n   = '0;
            state_n = STABLE_LOW;
          end else if (done) begin
            cnt_n   = '0;
            level_n = 1'b1;
            rise_n  = 1'b1;
            state_n = STABLE_HIGH;
          end else begin
            cnt_n = cnt_inc[VALUE_WIDTH-1:0];
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            if (done) begin
              level_n = 1'b0;
              fall_n  = 1'b1;
              state_n = STABLE_LOW;
            end else begin
              cnt_n   = cnt_inc[VALUE_WIDTH-1:0];
              state_n = COUNT_LOW;
            end
          end
        end
        COUNT_LOW: begin
          if (s) begin
            cnt_n   = '0;
            state_n = STABLE_HIGH;
          end else if (done) begin
            cnt_n   = '0;
            level_n = 1'b0;
            fall_n  = 1'b1;
            state_n = STABLE_LOW;
          end else begin
            cnt_n = cnt_inc[VALUE_WIDTH-1:0];
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = STABLE_LOW;
        end
      endcase
    end
  end

  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      state      <= STABLE_LOW;
      thr        <= THR_RST;
      cnt        <= '0;
      set_d      <= 1'b0;
      out_level  <= 1'b0;
      out_signal <= 1'b0;
      out_fall   <= 1'b0;
      out_ack    <= 1'b0;
    end else begin
      state      <= state_n;
      thr        <= thr_n;
      cnt        <= cnt_n;
      set_d      <= in_set;
      out_level  <= level_n;
      out_signal <= rise_n;
      out_fall   <= fall_n;
      out_ack    <= load;
    end
  end

endmodule
